// File: rtl/gray_to_binary_sync.sv
// Synchronizes a 4-bit Gray code from a foreign clock domain, decodes it to binary
// and checks every observed transition for the single-bit-step property.
module gray_to_binary_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       g1,
  input  logic       g2,
  input  logic       g3,
  input  logic       g4,
  input  logic       en,
  input  logic       err_clr,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  output logic       b4,
  output logic       valid,
  output logic       dir,
  output logic       step_err,
  output logic [3:0] err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [1:0] state_q, state_d;
  logic [3:0] prev_q, prev_d;
  logic [3:0] b_q, b_d;
  logic       valid_q, valid_d;
  logic       dir_q, dir_d;
  logic       step_err_q, step_err_d;
  logic [3:0] err_cnt_q, err_cnt_d;

  logic [3:0] gs;
  logic [3:0] bin;
  logic [3:0] diff;
  logic       err_inc;

  // Stage 0 captures the raw asynchronous bits; the last stage is the safe value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {g1, g2, g3, g4}};
  end

  assign gs   = sync_q[SYNC_STAGES-1];
  assign diff = gs ^ prev_q;

  always_comb begin
    bin[3] = gs[3];
    bin[2] = bin[3] ^ gs[2];
    bin[1] = bin[2] ^ gs[1];
    bin[0] = bin[1] ^ gs[0];
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    b_d        = b_q;
    dir_d      = dir_q;
    valid_d    = 1'b0;
    step_err_d = 1'b0;
    err_inc    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en) state_d = PRIME;
      end
      PRIME: begin
        prev_d  = gs;
        b_d     = bin;
        state_d = en ? TRACK : IDLE;
      end
      TRACK: begin
        // b_q always holds the decode of prev_q, so it serves as the old binary value.
        if ($onehot(diff)) begin
          valid_d = 1'b1;
          b_d     = bin;
          prev_d  = gs;
          dir_d   = (bin == b_q + 4'd1);
        end else if (diff != 4'd0) begin
          step_err_d = 1'b1;
          b_d        = bin;
          prev_d     = gs;
          err_inc    = 1'b1;
        end
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = 4'd0;
    end else if (err_inc && (err_cnt_q != 4'hF)) begin
      err_cnt_d = err_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      prev_q     <= 4'd0;
      b_q        <= 4'd0;
      valid_q    <= 1'b0;
      dir_q      <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= 4'd0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      prev_q     <= prev_d;
      b_q        <= b_d;
      valid_q    <= valid_d;
      dir_q      <= dir_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign b1       = b_q[3];
  assign b2       = b_q[2];
  assign b3       = b_q[1];
  assign b4       = b_q[0];
  assign valid    = valid_q;
  assign dir      = dir_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
